// File: rtl/mult_acc_seq_pkg.sv
// Shared constants and state encoding for the shift-and-add multiply-accumulate unit.
package mult_acc_seq_pkg;

   localparam int MUL_WIDTH = 32;
   localparam int MUL_ITER  = 32;
   localparam int CNT_W     = 6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/mult_acc_seq_if.sv
// Request/result bundle between a requester and mult_acc_seq.
interface mult_acc_seq_if
   import mult_acc_seq_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH
);
   logic                 start;
   logic [WIDTH-1:0]     multiplicand;
   logic [WIDTH-1:0]     multiplier;
   logic [WIDTH-1:0]     addend;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;

   modport master (
      output start, multiplicand, multiplier, addend,
      input  busy, done, product
   );

   modport slave (
      input  start, multiplicand, multiplier, addend,
      output busy, done, product
   );
endinterface

// File: rtl/mult_acc_seq_suma32bits.sv
// Ripple-carry adder with carry-out; additive twin of resta32bits.
module suma32bits
   import mult_acc_seq_pkg::*;
#(
   parameter int W = MUL_WIDTH
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] sum_o,
   output logic         carry_o
);

   logic cy;

   // Carry kept in a block-local variable so the chain stays a single combinational process.
   always_comb begin
      sum_o = '0;
      cy    = 1'b0;
      for (int i = 0; i < W; i++) begin
         sum_o[i] = a_i[i] ^ b_i[i] ^ cy;
         cy       = (a_i[i] & b_i[i]) | (cy & (a_i[i] ^ b_i[i]));
      end
      carry_o = cy;
   end

endmodule

// File: rtl/mult_acc_seq.sv
// Sequential shift-and-add multiply-accumulate: product = multiplicand * multiplier + addend.
//
// state   | meaning
// IDLE    | waiting for start; operands captured on the start edge
// RUN     | one partial-product add and right shift per edge
// DONE    | done pulse, product valid; start here chains a new run
module mult_acc_seq
   import mult_acc_seq_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH
) (
   input  logic          clk,
   input  logic          reset,
   mult_acc_seq_if.slave bus
);

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic [WIDTH-1:0]     mcand_q, mcand_d;
   logic [2*WIDTH-1:0]   prod_q, prod_d;

   logic [WIDTH-1:0]     pp;
   logic [WIDTH-1:0]     sum;
   logic                 carry;
   logic [WIDTH-1:0]     hi_sh;
   logic [WIDTH-1:0]     lo_sh;

   assign pp = lo_q[0] ? mcand_q : '0;

   suma32bits #(.W(WIDTH)) u_suma (
      .a_i     (hi_q),
      .b_i     (pp),
      .sum_o   (sum),
      .carry_o (carry)
   );

   // {carry, sum, lo} shifted right by one: the sum's LSB drops into the low word.
   assign hi_sh = {carry, sum[WIDTH-1:1]};
   assign lo_sh = {sum[0], lo_q[WIDTH-1:1]};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         mcand_q <= '0;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         mcand_q <= mcand_d;
         prod_q  <= prod_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      mcand_d = mcand_q;
      prod_d  = prod_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               mcand_d = bus.multiplicand;
               hi_d    = bus.addend;
               lo_d    = bus.multiplier;
               cnt_d   = '0;
               state_d = ST_RUN;
            end else if (state_q == ST_DONE) begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            hi_d  = hi_sh;
            lo_d  = lo_sh;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(MUL_ITER - 1)) begin
               prod_d  = {hi_sh, lo_sh};
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.busy    = (state_q == ST_RUN);
   assign bus.done    = (state_q == ST_DONE);
   assign bus.product = prod_q;

endmodule

// File: tb/tb_mult_acc_seq.sv
// Self-checking bench for mult_acc_seq: vector table, random runs vs. arithmetic model, corner sequences.
module tb_mult_acc_seq;

   logic clk;
   logic reset;

   mult_acc_seq_if #(.WIDTH(32)) bus ();

   mult_acc_seq #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs[4];
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c);
      return {32'd0, a} * {32'd0, b} + {32'd0, c};
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=0x%h expected=0x%h", name, got, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the start edge E0.
   task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      bus.start        = 1'b1;
      bus.multiplicand = a;
      bus.multiplier   = b;
      bus.addend       = c;
      @(posedge clk);
      @(negedge clk);
      bus.start        = 1'b0;
      bus.multiplicand = $urandom;
      bus.multiplier   = $urandom;
      bus.addend       = $urandom;
   endtask

   // Counts edges (E0 included) and busy cycles until done; returns in the done cycle.
   task automatic wait_done(output logic [63:0] p, output int edges, output int busy_cnt);
      edges    = 1;
      busy_cnt = 0;
      while (bus.done !== 1'b1 && edges < 100) begin
         if (bus.busy) busy_cnt++;
         @(posedge clk);
         @(negedge clk);
         edges++;
      end
      p = bus.product;
   endtask

   task automatic run_and_check(input string name, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] c, input logic [63:0] exp);
      logic [63:0] p;
      int          edges, busy_cnt;
      @(negedge clk);
      start_op(a, b, c);
      wait_done(p, edges, busy_cnt);
      check({name, " product"}, p, exp);
      check({name, " latency"}, 64'(edges), 64'd33);
      check({name, " busy cycles"}, 64'(busy_cnt), 64'd32);
      check({name, " busy in done"}, {63'd0, bus.busy}, 64'd0);
      @(negedge clk);
      check({name, " done one cycle"}, {63'd0, bus.done}, 64'd0);
      check({name, " product held"}, bus.product, exp);
   endtask

   initial begin
      logic [63:0] p;
      logic [63:0] prev;
      int          edges, busy_cnt, saw_done;
      logic [31:0] ra, rb, rc;

      vecs[0] = '{a: 32'd7,          b: 32'd6,          c: 32'd0,          exp: 64'h0000_0000_0000_002A};
      vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  c: 32'hFFFF_FFFF,  exp: 64'hFFFF_FFFF_0000_0000};
      vecs[2] = '{a: 32'h0000_020E,  b: 32'h0000_8042,  c: 32'h0000_7963,  exp: 64'h0000_0000_0108_00FF};
      vecs[3] = '{a: 32'h8000_0000,  b: 32'h0000_0002,  c: 32'h0000_0001,  exp: 64'h0000_0001_0000_0001};

      reset            = 1'b0;
      bus.start        = 1'b0;
      bus.multiplicand = '0;
      bus.multiplier   = '0;
      bus.addend       = '0;
      repeat (3) @(negedge clk);
      check("reset busy", {63'd0, bus.busy}, 64'd0);
      check("reset done", {63'd0, bus.done}, 64'd0);
      check("reset product", bus.product, 64'd0);
      reset = 1'b1;

      for (int i = 0; i < 4; i++)
         run_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].exp);

      for (int i = 0; i < 12; i++) begin
         ra = $urandom;
         rb = $urandom;
         rc = $urandom;
         if (i == 0) ra = 32'd0;
         if (i == 1) rb = 32'hFFFF_FFFF;
         run_and_check($sformatf("rand%0d", i), ra, rb, rc, model(ra, rb, rc));
      end

      // Back-to-back: start raised in the done cycle of the first run.
      @(negedge clk);
      start_op(32'd0, 32'h1234_5678, 32'd5);
      wait_done(p, edges, busy_cnt);
      check("b2b first product", p, 64'h5);
      check("b2b first latency", 64'(edges), 64'd33);
      start_op(32'd3, 32'd3, 32'd1);
      check("b2b no idle busy", {63'd0, bus.busy}, 64'd1);
      check("b2b done dropped", {63'd0, bus.done}, 64'd0);
      wait_done(p, edges, busy_cnt);
      check("b2b second product", p, 64'hA);
      check("b2b second latency", 64'(edges), 64'd33);

      // Start during RUN is ignored; product holds the previous result meanwhile.
      prev = bus.product;
      @(negedge clk);
      start_op(32'h0001_2345, 32'h0006_7890, 32'd9);
      repeat (10) begin
         @(posedge clk);
         @(negedge clk);
      end
      check("run product held", bus.product, prev);
      bus.start        = 1'b1;
      bus.multiplicand = 32'hDEAD_BEEF;
      bus.multiplier   = 32'h1111_1111;
      bus.addend       = 32'h2222_2222;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      check("run busy after ignored start", {63'd0, bus.busy}, 64'd1);
      wait_done(p, edges, busy_cnt);
      check("ignored start product", p, model(32'h0001_2345, 32'h0006_7890, 32'd9));
      check("ignored start latency", 64'(11 + edges), 64'd33);

      // Reset abort around iteration 20.
      @(negedge clk);
      start_op(32'hCAFE_0001, 32'h0BAD_F00D, 32'h1357_9BDF);
      repeat (19) begin
         @(posedge clk);
         @(negedge clk);
      end
      reset = 1'b0;
      #1;
      check("abort busy", {63'd0, bus.busy}, 64'd0);
      check("abort done", {63'd0, bus.done}, 64'd0);
      check("abort product", bus.product, 64'd0);
      repeat (2) @(negedge clk);
      reset    = 1'b1;
      saw_done = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done++;
      end
      check("abort no done", 64'(saw_done), 64'd0);
      run_and_check("after abort", 32'd2, 32'd3, 32'd4, 64'hA);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global timeout: got=stalled expected=finish");
      $fatal(1, "timeout");
   end

endmodule
